// File: rtl/maxpool_1d_param.sv
// Streaming 1-D max-pool: per-channel POOL_K-deep sliding window, emit every STRIDE beats once full.
// Optional fused ReLU on the output data when MAXPOOL_RELU_EN is defined.
module maxpool_1d_param #(
    parameter int DATA_W = 10,
    parameter int CH     = 5,
    parameter int POOL_K = 7,
    parameter int STRIDE = 2,
    parameter int CNT_W  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CH*DATA_W-1:0] in_data,
    input  logic                 in_val,
    input  logic                 in_last,
    output logic [CH*DATA_W-1:0] out_data,
    output logic                 out_val,
    output logic                 frame_done
);

    localparam logic [CNT_W-1:0] FILL_FULL   = CNT_W'(POOL_K);
    localparam logic [CNT_W-1:0] FILL_LAST   = CNT_W'(POOL_K - 1);
    localparam logic [CNT_W-1:0] STRIDE_LAST = CNT_W'(STRIDE - 1);

    logic [CNT_W-1:0] fill_q;
    logic [CNT_W-1:0] fill_d;
    logic [CNT_W-1:0] stride_q;
    logic [CNT_W-1:0] stride_d;
    logic             emit_d;
    logic             emit_q;
    logic             last_q;
    logic             out_val_q;
    logic             frame_done_q;

    always_comb begin
        fill_d   = fill_q;
        stride_d = stride_q;
        emit_d   = 1'b0;
        if (in_val) begin
            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + CNT_W'(1);
                if (fill_q == FILL_LAST) begin
                    emit_d   = 1'b1;
                    stride_d = '0;
                end
            end else if (stride_q == STRIDE_LAST) begin
                emit_d   = 1'b1;
                stride_d = '0;
            end else begin
                stride_d = stride_q + CNT_W'(1);
            end
            if (in_last) begin
                fill_d   = '0;
                stride_d = '0;
            end
        end
    end

    // Stage 1 captures the max of the post-update window at the accept edge, so a
    // frame-end beat can clear the window without losing its own compare result.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q       <= '0;
            stride_q     <= '0;
            emit_q       <= 1'b0;
            last_q       <= 1'b0;
            out_val_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            fill_q       <= fill_d;
            stride_q     <= stride_d;
            emit_q       <= emit_d;
            last_q       <= in_val & in_last;
            out_val_q    <= emit_q;
            frame_done_q <= last_q;
        end
    end

    assign out_val    = out_val_q;
    assign frame_done = frame_done_q;

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            logic signed [DATA_W-1:0] win_q     [POOL_K];
            logic signed [DATA_W-1:0] win_shift [POOL_K];
            logic signed [DATA_W-1:0] run_max;
            logic signed [DATA_W-1:0] relu_max;
            logic signed [DATA_W-1:0] max_q;
            logic signed [DATA_W-1:0] out_q;

            always_comb begin
                win_shift[0] = $signed(in_data[gi*DATA_W +: DATA_W]);
                for (int k = 1; k < POOL_K; k++) begin
                    win_shift[k] = win_q[k-1];
                end
            end

            always_ff @(posedge clk) begin
                if (rst || (in_val && in_last)) begin
                    for (int k = 0; k < POOL_K; k++) begin
                        win_q[k] <= '0;
                    end
                end else if (in_val) begin
                    for (int k = 0; k < POOL_K; k++) begin
                        win_q[k] <= win_shift[k];
                    end
                end
            end

            always_comb begin
                run_max = win_shift[0];
                for (int k = 1; k < POOL_K; k++) begin
                    if (win_shift[k] > run_max) begin
                        run_max = win_shift[k];
                    end
                end
            end

`ifdef MAXPOOL_RELU_EN
            assign relu_max = max_q[DATA_W-1] ? '0 : max_q;
`else
            assign relu_max = max_q;
`endif

            always_ff @(posedge clk) begin
                if (rst) begin
                    max_q <= '0;
                    out_q <= '0;
                end else begin
                    if (emit_d) begin
                        max_q <= run_max;
                    end
                    if (emit_q) begin
                        out_q <= relu_max;
                    end
                end
            end

            assign out_data[gi*DATA_W +: DATA_W] = out_q;
        end
    endgenerate

endmodule
